// File: rtl/node_mem_pkg.sv
// node_mem_pkg: node-memory widths, memory map and scanner state encoding shared by protocol-task FSMs
package node_mem_pkg;
  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_KSINK_CNT_ADDR = 'h688;
  localparam int unsigned DEF_NBR_CNT_ADDR = 'h68A;
  localparam int unsigned DEF_NBR_ID_BASE = 'h48;
  localparam int unsigned DEF_CLUSTER_ID_BASE = 'hC8;
  localparam int unsigned DEF_KSINK_BASE = 'h8;
  localparam int unsigned DEF_FLAG_ADDR = 'h2;
  localparam int unsigned DEF_MATCH_CNT_ADDR = 'h4;
  typedef enum logic [3:0] {
    IDLE, RD_KCNT, RD_NCNT, RD_NID, RD_CID, RD_KSINK, NEXT_NBR, WR_FLAG, WR_CNT, DONE
  } scan_state_t;
endpackage

// File: rtl/mem_read_timer.sv
// mem_read_timer: counts the cycles a read address is held and strobes sample on the last one
module mem_read_timer #(
  parameter int RD_LATENCY = 1
) (
  input  logic clock,
  input  logic nrst,
  input  logic run,
  output logic sample
);
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(RD_LATENCY - 1);
  logic [CW-1:0] cnt;
  assign sample = run && cnt == '0;
  // reload whenever a read completes so back-to-back reads each get the full hold time
  always_ff @(posedge clock or negedge nrst)
    if (!nrst) cnt <= LAST;
    else cnt <= (!run || sample) ? LAST : cnt - CW'(1);
endmodule

// File: rtl/sink_cluster_scanner.sv
// sink_cluster_scanner: counts neighbors that are known sinks in a foreign cluster and writes flag and count back
module sink_cluster_scanner
  import node_mem_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int MAX_COUNT = 32,
  parameter int STOP_ON_FIRST = 0,
  parameter int unsigned KSINK_CNT_ADDR = DEF_KSINK_CNT_ADDR,
  parameter int unsigned NBR_CNT_ADDR = DEF_NBR_CNT_ADDR,
  parameter int unsigned NBR_ID_BASE = DEF_NBR_ID_BASE,
  parameter int unsigned CLUSTER_ID_BASE = DEF_CLUSTER_ID_BASE,
  parameter int unsigned KSINK_BASE = DEF_KSINK_BASE,
  parameter int unsigned FLAG_ADDR = DEF_FLAG_ADDR,
  parameter int unsigned MATCH_CNT_ADDR = DEF_MATCH_CNT_ADDR
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] my_cluster_id,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  for_aggregation,
  output logic [WORD_WIDTH-1:0] match_count,
  output logic                  error
);
  localparam int IW = $clog2(MAX_COUNT + 1);
  localparam logic [WORD_WIDTH-1:0] MAXC = WORD_WIDTH'(MAX_COUNT);
  localparam logic [ADDR_WIDTH-1:0] A_KCNT = ADDR_WIDTH'(KSINK_CNT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_NCNT = ADDR_WIDTH'(NBR_CNT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_NID = ADDR_WIDTH'(NBR_ID_BASE);
  localparam logic [ADDR_WIDTH-1:0] A_CID = ADDR_WIDTH'(CLUSTER_ID_BASE);
  localparam logic [ADDR_WIDTH-1:0] A_KS = ADDR_WIDTH'(KSINK_BASE);
  localparam logic [ADDR_WIDTH-1:0] A_FLAG = ADDR_WIDTH'(FLAG_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_MC = ADDR_WIDTH'(MATCH_CNT_ADDR);
  scan_state_t state;
  logic [WORD_WIDTH-1:0] kcnt, ncnt, nid, mc_inc;
  logic [IW-1:0] i, j;
  logic rd_state, sample, hit, last_i, last_j;
  // table entries are 16-bit words at byte addresses, wrapping at the address width
  function automatic logic [ADDR_WIDTH-1:0] ent(input logic [ADDR_WIDTH-1:0] base, input logic [IW-1:0] k);
    return base + (ADDR_WIDTH'(k) << 1);
  endfunction
  assign rd_state = state inside {RD_KCNT, RD_NCNT, RD_NID, RD_CID, RD_KSINK};
  assign hit = data_in == nid;
  assign mc_inc = &match_count ? match_count : match_count + WORD_WIDTH'(1);
  assign last_i = WORD_WIDTH'(i) == ncnt - WORD_WIDTH'(1);
  assign last_j = WORD_WIDTH'(j) == kcnt - WORD_WIDTH'(1);
  mem_read_timer #(.RD_LATENCY(RD_LATENCY)) u_timer (
    .clock(clock),
    .nrst(nrst),
    .run(rd_state),
    .sample(sample)
  );
  always_ff @(posedge clock or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      address <= A_KCNT;
      wr_en <= 1'b0;
      data_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      for_aggregation <= 1'b0;
      match_count <= '0;
      error <= 1'b0;
      i <= '0;
      j <= '0;
      kcnt <= '0;
      ncnt <= '0;
      nid <= '0;
    end else case (state)
      IDLE, DONE: if (start) begin
        state <= RD_KCNT;
        address <= A_KCNT;
        busy <= 1'b1;
        done <= 1'b0;
        for_aggregation <= 1'b0;
        match_count <= '0;
        error <= 1'b0;
        i <= '0;
        j <= '0;
      end
      RD_KCNT: if (sample) begin
        kcnt <= data_in;
        address <= A_NCNT;
        state <= RD_NCNT;
      end
      RD_NCNT: if (sample) begin
        ncnt <= data_in;
        // oversized or empty tables skip straight to writing a zero flag
        if (kcnt > MAXC || data_in > MAXC || kcnt == '0 || data_in == '0) begin
          error <= kcnt > MAXC || data_in > MAXC;
          state <= WR_FLAG;
          address <= A_FLAG;
          data_out <= '0;
          for_aggregation <= 1'b0;
          wr_en <= 1'b1;
        end else begin
          state <= RD_NID;
          address <= ent(A_NID, '0);
        end
      end
      RD_NID: if (sample) begin
        nid <= data_in;
        address <= ent(A_CID, i);
        state <= RD_CID;
      end
      RD_CID: if (sample) begin
        if (data_in == my_cluster_id) state <= NEXT_NBR;
        else begin
          j <= '0;
          address <= ent(A_KS, '0);
          state <= RD_KSINK;
        end
      end
      RD_KSINK: if (sample) begin
        if (hit) match_count <= mc_inc;
        if (hit && STOP_ON_FIRST != 0) begin
          state <= WR_FLAG;
          address <= A_FLAG;
          data_out <= WORD_WIDTH'(1);
          for_aggregation <= 1'b1;
          wr_en <= 1'b1;
        end else if (last_j) state <= NEXT_NBR;
        else begin
          j <= j + IW'(1);
          address <= ent(A_KS, j + IW'(1));
        end
      end
      NEXT_NBR: if (last_i) begin
        state <= WR_FLAG;
        address <= A_FLAG;
        data_out <= WORD_WIDTH'(match_count != '0);
        for_aggregation <= match_count != '0;
        wr_en <= 1'b1;
      end else begin
        i <= i + IW'(1);
        j <= '0;
        address <= ent(A_NID, i + IW'(1));
        state <= RD_NID;
      end
      WR_FLAG: begin
        address <= A_MC;
        data_out <= match_count;
        state <= WR_CNT;
      end
      WR_CNT: begin
        wr_en <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
        state <= DONE;
      end
      default: begin
        state <= IDLE;
        wr_en <= 1'b0;
        busy <= 1'b0;
      end
    endcase
endmodule

// File: tb/tb_sink_cluster_scanner.sv
// tb_sink_cluster_scanner: two scanner instances (latency 1 full scan, latency 3 stop-on-first) against a trace model
module tb_sink_cluster_scanner;
  localparam logic [15:0] KCNT_A = 16'h688, NCNT_A = 16'h68A, NID_A = 16'h48, CID_A = 16'hC8;
  localparam logic [15:0] KS_A = 16'h8, FLAG_A = 16'h2, MC_A = 16'h4;
  logic clock = 1'b0, nrst = 1'b0;
  logic [15:0] myc = 16'd1;
  logic [1:0] st = '0, wr, bsy, dn, fa, er;
  logic [1:0][15:0] din = '0, addr_o, dout, mcnt;
  logic [15:0] mem [0:2047];
  int checks = 0, errors = 0;
  int age [2] = '{0, 0};
  logic [15:0] prev [2] = '{16'h0, 16'h0};
  logic [15:0] e_addr[$], e_dat[$];
  bit e_care[$], e_wr[$];
  int m_mc, cyc, nid_hits;
  bit m_err;
  logic [31:0] wlog[$];

  always #5 clock = ~clock;

  sink_cluster_scanner dut0 (
    .clock(clock), .nrst(nrst), .start(st[0]), .my_cluster_id(myc), .data_in(din[0]),
    .address(addr_o[0]), .wr_en(wr[0]), .data_out(dout[0]), .busy(bsy[0]), .done(dn[0]),
    .for_aggregation(fa[0]), .match_count(mcnt[0]), .error(er[0])
  );
  sink_cluster_scanner #(.RD_LATENCY(3), .STOP_ON_FIRST(1)) dut1 (
    .clock(clock), .nrst(nrst), .start(st[1]), .my_cluster_id(myc), .data_in(din[1]),
    .address(addr_o[1]), .wr_en(wr[1]), .data_out(dout[1]), .busy(bsy[1]), .done(dn[1]),
    .for_aggregation(fa[1]), .match_count(mcnt[1]), .error(er[1])
  );

  function automatic logic [15:0] rdm(input logic [15:0] a);
    return mem[a[11:1]];
  endfunction

  task automatic setw(input logic [15:0] a, input logic [15:0] v);
    mem[a[11:1]] = v;
  endtask

  // memory returns corrupted data until the address has been held for the instance's latency
  always @(negedge clock)
    for (int d = 0; d < 2; d++) begin
      age[d] = (addr_o[d] == prev[d]) ? age[d] + 1 : 1;
      prev[d] = addr_o[d];
      din[d] = (age[d] >= (d == 1 ? 3 : 1)) ? rdm(addr_o[d]) : rdm(addr_o[d]) ^ 16'hA5A5;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] a, input bit c, input bit w, input logic [15:0] v);
    e_addr.push_back(a);
    e_care.push_back(c);
    e_wr.push_back(w);
    e_dat.push_back(v);
  endtask

  task automatic rd(input logic [15:0] a, input int lat);
    for (int c = 0; c < lat; c++) push(a, 1'b1, 1'b0, 16'h0);
  endtask

  // expected busy-cycle trace: each read held lat cycles, one don't-care cycle per neighbor advance
  task automatic build(input int d);
    int lat, k, n;
    bit stop, fin;
    logic [15:0] nid;
    lat = (d == 1) ? 3 : 1;
    stop = d == 1;
    e_addr.delete(); e_care.delete(); e_wr.delete(); e_dat.delete();
    rd(KCNT_A, lat);
    rd(NCNT_A, lat);
    k = int'(rdm(KCNT_A));
    n = int'(rdm(NCNT_A));
    m_mc = 0;
    m_err = k > 32 || n > 32;
    fin = 1'b0;
    if (!m_err && k > 0 && n > 0)
      for (int i = 0; i < n && !fin; i++) begin
        nid = rdm(NID_A + 16'(2 * i));
        rd(NID_A + 16'(2 * i), lat);
        rd(CID_A + 16'(2 * i), lat);
        if (rdm(CID_A + 16'(2 * i)) != myc)
          for (int j = 0; j < k && !fin; j++) begin
            rd(KS_A + 16'(2 * j), lat);
            if (rdm(KS_A + 16'(2 * j)) == nid) begin
              m_mc = (m_mc == 65535) ? m_mc : m_mc + 1;
              fin = stop;
            end
          end
        if (!fin) push(16'h0, 1'b0, 1'b0, 16'h0);
      end
    push(FLAG_A, 1'b1, 1'b1, 16'(m_mc != 0));
    push(MC_A, 1'b1, 1'b1, 16'(m_mc));
  endtask

  task automatic run_scan(input int d);
    build(d);
    wlog.delete();
    nid_hits = 0;
    cyc = 0;
    @(negedge clock);
    st[d] = 1'b1;
    forever begin
      @(negedge clock);
      st[d] = 1'b0;
      if (cyc == 0) begin
        chk("start_clears_count", 32'(mcnt[d]), 0);
        chk("start_clears_done", 32'(dn[d]), 0);
      end
      if (dn[d] || cyc > e_addr.size() + 20) break;
      if (wr[d]) wlog.push_back({addr_o[d], dout[d]});
      if (addr_o[d] == NID_A + 16'd2 || addr_o[d] == NID_A + 16'd4) nid_hits++;
      if (cyc < e_addr.size()) begin
        if (e_care[cyc]) chk("address", 32'(addr_o[d]), 32'(e_addr[cyc]));
        chk("wr_en", 32'(wr[d]), 32'(e_wr[cyc]));
        if (e_wr[cyc]) chk("write_data", 32'(dout[d]), 32'(e_dat[cyc]));
        chk("busy", 32'(bsy[d]), 1);
      end
      cyc++;
    end
    chk("busy_cycles", cyc, e_addr.size());
    chk("done_busy", 32'(bsy[d]), 0);
    chk("done_wr_en", 32'(wr[d]), 0);
    chk("match_count", 32'(mcnt[d]), m_mc);
    chk("for_aggregation", 32'(fa[d]), 32'(m_mc != 0));
    chk("error", 32'(er[d]), 32'(m_err));
  endtask

  task automatic chk_reset(input int d);
    chk("rst_address", 32'(addr_o[d]), 32'(KCNT_A));
    chk("rst_wr_en", 32'(wr[d]), 0);
    chk("rst_data_out", 32'(dout[d]), 0);
    chk("rst_busy", 32'(bsy[d]), 0);
    chk("rst_done", 32'(dn[d]), 0);
    chk("rst_flag", 32'(fa[d]), 0);
    chk("rst_match_count", 32'(mcnt[d]), 0);
    chk("rst_error", 32'(er[d]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0;
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) chk_reset(d);
    nrst = 1'b1;
    // match found on the second neighbor after the first is skipped as same-cluster
    setw(KCNT_A, 16'd2); setw(KS_A, 16'd5); setw(KS_A + 16'd2, 16'd9);
    setw(NCNT_A, 16'd2); setw(NID_A, 16'd3); setw(NID_A + 16'd2, 16'd9);
    setw(CID_A, 16'd1); setw(CID_A + 16'd2, 16'd2);
    myc = 16'd1;
    run_scan(0);
    chk("t1_cycles", cyc, 12);
    chk("t1_match_count", 32'(mcnt[0]), 1);
    chk("t1_num_writes", wlog.size(), 2);
    chk("t1_write0", wlog[0], {16'h2, 16'h1});
    chk("t1_write1", wlog[1], {16'h4, 16'h1});
    run_scan(1);
    chk("lat3_cycles", cyc, 27);
    chk("lat3_match_count", 32'(mcnt[1]), 1);
    // the only sink-bearing neighbor now shares our cluster
    setw(CID_A + 16'd2, 16'd1);
    run_scan(0);
    chk("t2_cycles", cyc, 10);
    chk("t2_flag", 32'(fa[0]), 0);
    chk("t2_write0", wlog[0], {16'h2, 16'h0});
    chk("t2_write1", wlog[1], {16'h4, 16'h0});
    // every neighbor is a foreign sink
    setw(NCNT_A, 16'd3);
    setw(NID_A, 16'd5); setw(NID_A + 16'd2, 16'd9); setw(NID_A + 16'd4, 16'd5);
    setw(CID_A, 16'd2); setw(CID_A + 16'd2, 16'd2); setw(CID_A + 16'd4, 16'd2);
    run_scan(1);
    chk("stop_match_count", 32'(mcnt[1]), 1);
    chk("stop_cycles", cyc, 17);
    chk("stop_no_later_nid", nid_hits, 0);
    run_scan(0);
    chk("all_match_count", 32'(mcnt[0]), 3);
    setw(NCNT_A, 16'd0);
    run_scan(0);
    chk("ncnt0_cycles", cyc, 4);
    chk("ncnt0_match_count", 32'(mcnt[0]), 0);
    setw(NCNT_A, 16'd2); setw(KCNT_A, 16'd33);
    run_scan(0);
    chk("range_error", 32'(er[0]), 1);
    chk("range_cycles", cyc, 4);
    chk("range_write0", wlog[0], {16'h2, 16'h0});
    chk("range_write1", wlog[1], {16'h4, 16'h0});
    // abort during the second sink read of neighbor 0, after one match was counted
    setw(KCNT_A, 16'd2); setw(NCNT_A, 16'd3);
    @(negedge clock);
    st[0] = 1'b1;
    @(negedge clock);
    st[0] = 1'b0;
    repeat (5) @(negedge clock);
    chk("abort_in_ksink", 32'(addr_o[0]), 32'(KS_A + 16'd2));
    chk("abort_count_before", 32'(mcnt[0]), 1);
    nrst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk_reset(d);
    @(negedge clock);
    nrst = 1'b1;
    for (int r = 0; r < 24; r++) begin
      setw(KCNT_A, ($urandom_range(0, 9) == 0) ? 16'd33 : 16'($urandom_range(0, 5)));
      setw(NCNT_A, ($urandom_range(0, 9) == 0) ? 16'd33 : 16'($urandom_range(0, 5)));
      for (int e = 0; e < 6; e++) begin
        setw(KS_A + 16'(2 * e), 16'($urandom_range(1, 6)));
        setw(NID_A + 16'(2 * e), 16'($urandom_range(1, 6)));
        setw(CID_A + 16'(2 * e), 16'($urandom_range(1, 3)));
      end
      myc = 16'($urandom_range(1, 3));
      run_scan(r % 2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sink_cluster_scanner.md
Name: sink_cluster_scanner

Overview:
- Scans the node's neighbor table against the known-sink list held in node memory.
- Counts neighbors that are known sinks in a foreign cluster.
- Writes the aggregation flag and the match count back to memory.
- Parametrised successor of the single-flag neighbor/sink checker: configurable widths, memory map, read latency, table limits and early-exit mode; adds same-cluster skip, match counting, range error and restartability. Sits on the node memory port beside the other protocol-task FSMs and is started by the node controller.

Parameters:
- WORD_WIDTH, 16, data/ID width
- ADDR_WIDTH, 16, memory address width
- RD_LATENCY, 1, cycles address is held before data_in is sampled (>=1)
- MAX_COUNT, 32, largest legal neighbor or known-sink count
- STOP_ON_FIRST, 0, 1 = stop scanning at first match
- KSINK_CNT_ADDR, 'h688, known-sink count word
- NBR_CNT_ADDR, 'h68A, neighbor count word
- NBR_ID_BASE, 'h48, neighbor ID table base
- CLUSTER_ID_BASE, 'hC8, neighbor cluster ID table base
- KSINK_BASE, 'h8, known-sink table base
- FLAG_ADDR, 'h2, forAggregation flag word
- MATCH_CNT_ADDR, 'h4, match count word

Ports:
- clock  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  begin scan; sampled only in IDLE or DONE
- my_cluster_id  in  WORD_WIDTH  own cluster ID; must be stable while busy
- data_in  in  WORD_WIDTH  memory read data
- address  out  ADDR_WIDTH  memory address
- wr_en  out  1  memory write strobe, one cycle per write
- data_out  out  WORD_WIDTH  memory write data
- busy  out  1  high from start acceptance until DONE
- done  out  1  high in DONE until next start
- for_aggregation  out  1  final flag, valid while done
- match_count  out  WORD_WIDTH  number of matches, valid while done
- error  out  1  count exceeded MAX_COUNT, valid while done

Behaviour:
- Reset (async, nrst=0): state IDLE; address=KSINK_CNT_ADDR; wr_en=0; data_out=0; busy=0; done=0; for_aggregation=0; match_count=0; error=0; i=j=0.
- Table entry addresses are byte addresses: entry k = BASE + 2*k, computed modulo 2^ADDR_WIDTH.
- Read rule: address is held for RD_LATENCY cycles; data_in is sampled on the edge ending the last of those cycles.
- States:
  - IDLE/DONE: on start, clear match_count, for_aggregation, error, i, j and done; set busy; go RD_KCNT.
  - RD_KCNT: latch kcnt; go RD_NCNT.
  - RD_NCNT: latch ncnt, then:
    - kcnt>MAX_COUNT or ncnt>MAX_COUNT: error=1, go WR_FLAG (flag 0);
    - ncnt==0 or kcnt==0: go WR_FLAG;
    - else go RD_NID.
  - RD_NID: latch neighbor ID (entry i); go RD_CID.
  - RD_CID: latch cluster ID (entry i); if it equals my_cluster_id, go NEXT_NBR with no sink reads; else go RD_KSINK with j=0.
  - RD_KSINK: read sink entry j and compare with the neighbor ID. On match, match_count+1, saturating at all-ones.
    - match and STOP_ON_FIRST=1: go WR_FLAG;
    - j==kcnt-1: go NEXT_NBR;
    - else j+1, stay.
  - NEXT_NBR (1 cycle): if i==ncnt-1 go WR_FLAG; else i+1, j=0, go RD_NID.
  - WR_FLAG (1 cycle): address=FLAG_ADDR, data_out=(match_count!=0), wr_en=1; for_aggregation updated to the same value; go WR_CNT.
  - WR_CNT (1 cycle): address=MATCH_CNT_ADDR, data_out=match_count, wr_en=1; go DONE.
  - DONE: busy=0, done=1, wr_en=0; outputs held.
- The flag is always written (0 or 1); the count is always written, including on error.
- start while busy is ignored.
- Reset mid-scan aborts immediately with no partial write; wr_en drops asynchronously.
- Illegal state encoding goes to IDLE.

Decomposition:
- Shared package (node_mem_pkg): WORD_WIDTH and ADDR_WIDTH defaults, all memory-map address constants, and the state enum typedef.
- One natural sub-module: mem_read_timer, a RD_LATENCY down-counter issuing a sample strobe. The FSM stays in the parent.

Test Plan:
- Match found, RD_LATENCY=1: kcnt=2 (sinks 5,9), ncnt=2 (IDs 3,9; clusters 1,2), my_cluster_id=1 -> neighbor 0 skips sink reads; match at j=1; writes 1 to 'h2 then 1 to 'h4; done after 12 cycles.
- No foreign match: same tables, cluster of ID 9 = 1 -> no sink reads at all; writes 0 then 0; for_aggregation=0.
- STOP_ON_FIRST=1: ncnt=3, every neighbor a foreign sink -> match_count=1, no RD_NID for i=1 or i=2.
- STOP_ON_FIRST=0, same tables -> match_count=3.
- Boundaries:
  - ncnt=0 -> no table reads, flag 0 written.
  - kcnt=MAX_COUNT+1 -> error=1, flag 0, count 0 written.
  - RD_LATENCY=3 -> every read address held exactly 3 cycles.
- Robustness: nrst pulsed mid-RD_KSINK -> all outputs return to reset values asynchronously with no write; a second start after DONE re-runs and clears the prior match_count.
